// File: rtl/mips_pkg.sv
// Shared types and constants for the single-cycle MIPS core datapath.
// Used by the register file/writeback stage and its exception controller.
package mips_pkg;

   localparam int DW   = 32;
   localparam int NREG = 32;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   typedef enum logic {
      EXC_IDLE = 1'b0,
      EXC_PEND = 1'b1
   } exc_state_t;

endpackage

// File: rtl/ovf_exc_ctrl.sv
// Overflow exception controller: IDLE/PEND state machine with the EPC,
// faulting destination register and a saturating exception counter.
module ovf_exc_ctrl #(
   parameter int AW   = 5,
   parameter int CNTW = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic                ovf,
   input  logic [AW-1:0]       wa,
   input  mips_pkg::word_t     pc,
   input  logic                exc_ack,
   output logic                exc_valid,
   output mips_pkg::word_t     epc,
   output logic [AW-1:0]       exc_reg,
   output logic [CNTW-1:0]     exc_cnt
);
   import mips_pkg::*;

   exc_state_t      state_reg;
   logic            exc_valid_reg;
   word_t           epc_reg;
   logic [AW-1:0]   exc_reg_reg;
   logic [CNTW-1:0] exc_cnt_reg;
   logic            trap;
   logic [CNTW-1:0] cnt_next;

   // ovf only matters for an instruction that actually writes back
   assign trap     = we & ovf;
   assign cnt_next = (exc_cnt_reg == {CNTW{1'b1}}) ? exc_cnt_reg : exc_cnt_reg + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= EXC_IDLE;
         exc_valid_reg <= 1'b0;
         epc_reg       <= '0;
         exc_reg_reg   <= '0;
         exc_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            EXC_IDLE: begin
               if (trap) begin
                  state_reg     <= EXC_PEND;
                  exc_valid_reg <= 1'b1;
                  epc_reg       <= pc;
                  exc_reg_reg   <= wa;
                  exc_cnt_reg   <= cnt_next;
               end
            end
            EXC_PEND: begin
               // A fault arriving with the ack re-arms instead of clearing
               if (exc_ack && trap) begin
                  epc_reg     <= pc;
                  exc_reg_reg <= wa;
                  exc_cnt_reg <= cnt_next;
               end else if (exc_ack) begin
                  state_reg     <= EXC_IDLE;
                  exc_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= EXC_IDLE;
               exc_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign exc_valid = exc_valid_reg;
   assign epc       = epc_reg;
   assign exc_reg   = exc_reg_reg;
   assign exc_cnt   = exc_cnt_reg;

endmodule

// File: rtl/gpr_writeback.sv
// General-purpose register file and writeback stage: two combinational read
// ports with optional same-cycle forwarding, commit gated by overflow traps.
module gpr_writeback #(
   parameter int DW     = mips_pkg::DW,
   parameter int NREG   = mips_pkg::NREG,
   parameter int BYPASS = 1,
   parameter int CNTW   = 8,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [AW-1:0]       ra1,
   input  logic [AW-1:0]       ra2,
   output logic [DW-1:0]       rd1,
   output logic [DW-1:0]       rd2,
   input  logic                we,
   input  logic [AW-1:0]       wa,
   input  logic [DW-1:0]       wd,
   input  logic                ovf,
   input  mips_pkg::word_t     pc,
   input  logic                exc_ack,
   output logic                exc_valid,
   output mips_pkg::word_t     epc,
   output logic [AW-1:0]       exc_reg,
   output logic [CNTW-1:0]     exc_cnt
);
   import mips_pkg::*;

   logic [NREG-1:0][DW-1:0] regs;
   logic                    commit;

   assign commit = we & ~ovf & ~exc_valid & (wa != AW'(ZERO_REG));

   // r0 has no storage, so it can never hold anything but zero
   assign regs[0] = '0;

   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
         logic [DW-1:0] q_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               q_reg <= '0;
            else if (commit && (wa == AW'(gi)))
               q_reg <= wd;
         end
         assign regs[gi] = q_reg;
      end
   endgenerate

   // commit already excludes r0, so forwarding never leaks into r0 reads
   always_comb begin
      rd1 = regs[ra1];
      rd2 = regs[ra2];
      if (BYPASS != 0 && commit) begin
         if (ra1 == wa) rd1 = wd;
         if (ra2 == wa) rd2 = wd;
      end
   end

   ovf_exc_ctrl #(
      .AW   (AW),
      .CNTW (CNTW)
   ) u_exc (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .ovf       (ovf),
      .wa        (wa),
      .pc        (pc),
      .exc_ack   (exc_ack),
      .exc_valid (exc_valid),
      .epc       (epc),
      .exc_reg   (exc_reg),
      .exc_cnt   (exc_cnt)
   );

endmodule
